// File: rtl/demux_stream_1ton_if.sv
// Stream bundle for the 1-to-NUM_CH demultiplexer: the producer handshake, per-channel
// consumer handshakes and drop-error status.
interface demux_stream_1ton_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 8
);
    logic                     s_valid;
    logic                     s_ready;
    logic [DATA_W-1:0]        s_data;
    logic [SEL_W-1:0]         s_sel;
    logic                     s_bcast;
    logic [NUM_CH-1:0]        m_valid;
    logic [NUM_CH-1:0]        m_ready;
    logic [NUM_CH*DATA_W-1:0] m_data;
    logic                     err;
    logic [CNT_W-1:0]         err_cnt;

    modport slave (
        input  s_valid, s_data, s_sel, s_bcast, m_ready,
        output s_ready, m_valid, m_data, err, err_cnt
    );

    modport master (
        output s_valid, s_data, s_sel, s_bcast, m_ready,
        input  s_ready, m_valid, m_data, err, err_cnt
    );
endinterface

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-NUM_CH stream demultiplexer with one-entry buffer per channel,
// broadcast mode and saturating count of words dropped for an out-of-range select.
module demux_stream_1ton #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 8,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 8
) (
    input logic                clk,
    input logic                rst_n,
    demux_stream_1ton_if.slave bus
);
    logic [NUM_CH-1:0]        m_valid_q, m_valid_d;
    logic [NUM_CH*DATA_W-1:0] m_data_q, m_data_d;
    logic                     err_q, err_d;
    logic [CNT_W-1:0]         err_cnt_q, err_cnt_d;

    logic [NUM_CH-1:0]        free;
    logic [NUM_CH-1:0]        uni_hit;
    logic [NUM_CH-1:0]        load;
    logic                     in_range;
    logic                     s_ready;
    logic                     accept;
    logic                     drop;

    // A select matching no channel is out of range; such words are always accepted and dropped.
    always_comb begin
        free    = ~m_valid_q | bus.m_ready;
        uni_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            uni_hit[i] = (bus.s_sel == SEL_W'(i));
        end
        in_range = |uni_hit;

        if (bus.s_bcast) begin
            s_ready = &free;
        end else if (in_range) begin
            s_ready = |(free & uni_hit);
        end else begin
            s_ready = 1'b1;
        end

        accept = bus.s_valid & s_ready;
        drop   = accept & ~bus.s_bcast & ~in_range;
        if (!accept) begin
            load = '0;
        end else if (bus.s_bcast) begin
            load = {NUM_CH{1'b1}};
        end else begin
            load = uni_hit;
        end
    end

    // A load wins over a simultaneous drain, keeping one word per cycle per channel.
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (load[i]) begin
                m_valid_d[i]                  = 1'b1;
                m_data_d[i*DATA_W +: DATA_W]  = bus.s_data;
            end else if (m_valid_q[i] && bus.m_ready[i]) begin
                m_valid_d[i] = 1'b0;
            end
        end

        err_d     = drop;
        err_cnt_d = err_cnt_q;
        if (drop && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= '0;
            m_data_q  <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_demux_stream_1ton.sv
// Bench for demux_stream_1ton: an 8-channel instance driven from a vector table with a
// per-channel scoreboard, and a 6-channel instance for the out-of-range error path.
module tb_demux_stream_1ton;
    localparam int DW  = 8;
    localparam int NCH = 8;
    localparam int SW  = 3;
    localparam int CW  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux_stream_1ton_if #(.DATA_W(DW), .NUM_CH(NCH), .SEL_W(SW), .CNT_W(CW)) bus8 ();
    demux_stream_1ton_if #(.DATA_W(DW), .NUM_CH(6),   .SEL_W(SW), .CNT_W(CW)) bus6 ();

    demux_stream_1ton #(.DATA_W(DW), .NUM_CH(NCH), .SEL_W(SW), .CNT_W(CW)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    demux_stream_1ton #(.DATA_W(DW), .NUM_CH(6), .SEL_W(SW), .CNT_W(CW)) u_dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6.slave)
    );

    typedef struct {
        logic       v;
        logic       bc;
        logic [2:0] sel;
        logic [7:0] d;
        logic [7:0] mr;
        logic       rdy;
        logic [7:0] mv;
    } vec_t;

    typedef logic [7:0] byte_q_t[$];

    vec_t    vecs[$];
    byte_q_t sbq[NCH];
    int      checks = 0;
    int      failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; samples 1 time unit before the rising edge, then 1 after it.
    task automatic step8(input vec_t t);
        logic [7:0] full;
        logic [7:0] free;
        logic       mrdy;
        bus8.s_valid = t.v;
        bus8.s_bcast = t.bc;
        bus8.s_sel   = t.sel;
        bus8.s_data  = t.d;
        bus8.m_ready = t.mr;
        #4;
        for (int i = 0; i < NCH; i++) full[i] = (sbq[i].size() != 0);
        free = ~full | t.mr;
        mrdy = t.bc ? &free : free[t.sel];
        check("s_ready_model", {63'd0, bus8.s_ready}, {63'd0, mrdy});
        check("s_ready_table", {63'd0, bus8.s_ready}, {63'd0, t.rdy});
        check("m_valid_pre", {56'd0, bus8.m_valid}, {56'd0, full});
        for (int i = 0; i < NCH; i++) begin
            if (full[i] && t.mr[i]) begin
                check($sformatf("sb_data_ch%0d", i), {56'd0, bus8.m_data[i*DW +: DW]}, {56'd0, sbq[i][0]});
                void'(sbq[i].pop_front());
            end
        end
        if (t.v && mrdy) begin
            for (int i = 0; i < NCH; i++) begin
                if (t.bc || (t.sel == 3'(i))) sbq[i].push_back(t.d);
            end
        end
        @(posedge clk);
        #1;
        check("m_valid_post", {56'd0, bus8.m_valid}, {56'd0, t.mv});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus8.s_valid = 1'b0; bus8.s_bcast = 1'b0; bus8.s_sel = '0; bus8.s_data = '0; bus8.m_ready = '1;
        bus6.s_valid = 1'b0; bus6.s_bcast = 1'b0; bus6.s_sel = '0; bus6.s_data = '0; bus6.m_ready = '1;

        // Reset state
        @(negedge clk);
        check("rst_m_valid", {56'd0, bus8.m_valid}, 64'd0);
        check("rst_m_data", bus8.m_data, 64'd0);
        check("rst_err", {63'd0, bus8.err}, 64'd0);
        check("rst_err_cnt", {56'd0, bus8.err_cnt}, 64'd0);
        rst_n = 1'b1;

        // Routing, backpressure, broadcast
        vecs.push_back('{1'b1, 1'b0, 3'd5, 8'hA5, 8'hFF, 1'b1, 8'h20});
        vecs.push_back('{1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00});
        vecs.push_back('{1'b1, 1'b0, 3'd2, 8'h11, 8'hFB, 1'b1, 8'h04});
        vecs.push_back('{1'b1, 1'b0, 3'd2, 8'h22, 8'hFB, 1'b0, 8'h04});
        vecs.push_back('{1'b1, 1'b0, 3'd3, 8'h33, 8'hFB, 1'b1, 8'h0C});
        vecs.push_back('{1'b1, 1'b0, 3'd2, 8'h22, 8'hFF, 1'b1, 8'h04});
        vecs.push_back('{1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00});
        vecs.push_back('{1'b1, 1'b0, 3'd1, 8'h77, 8'hFD, 1'b1, 8'h02});
        vecs.push_back('{1'b1, 1'b1, 3'd0, 8'h3C, 8'hFD, 1'b0, 8'h02});
        vecs.push_back('{1'b1, 1'b1, 3'd0, 8'h3C, 8'hFD, 1'b0, 8'h02});
        vecs.push_back('{1'b1, 1'b1, 3'd0, 8'h3C, 8'hFF, 1'b1, 8'hFF});
        vecs.push_back('{1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00});
        // Throughput: 16 back-to-back words cycling through all channels
        for (int i = 0; i < 16; i++) begin
            vecs.push_back('{1'b1, 1'b0, 3'(i % 8), 8'(8'h40 + i), 8'hFF, 1'b1, 8'(1 << (i % 8))});
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step8(vecs[i]);
            if (i == 0) check("route_m_data", bus8.m_data, 64'h0000_A500_0000_0000);
            if (i == 10) check("bcast_m_data", bus8.m_data, 64'h3C3C_3C3C_3C3C_3C3C);
        end

        // Error path on the 6-channel instance
        bus6.s_valid = 1'b1; bus6.s_sel = 3'd7; bus6.s_data = 8'hEE;
        #4;
        check("err_s_ready", {63'd0, bus6.s_ready}, 64'd1);
        @(posedge clk); #1;
        check("err_pulse", {63'd0, bus6.err}, 64'd1);
        check("err_cnt_1", {56'd0, bus6.err_cnt}, 64'd1);
        check("err_m_valid", {58'd0, bus6.m_valid}, 64'd0);
        @(negedge clk);
        bus6.s_valid = 1'b0;
        @(posedge clk); #1;
        check("err_pulse_end", {63'd0, bus6.err}, 64'd0);
        check("err_cnt_hold", {56'd0, bus6.err_cnt}, 64'd1);
        @(negedge clk);
        bus6.s_valid = 1'b1; bus6.s_sel = 3'd6;
        @(posedge clk); #1;
        check("err_sel6_cnt", {56'd0, bus6.err_cnt}, 64'd2);
        @(negedge clk);
        bus6.s_sel = 3'd5; bus6.s_data = 8'h5A; bus6.m_ready = '0;
        @(posedge clk); #1;
        check("ch5_m_valid", {58'd0, bus6.m_valid}, 64'h20);
        check("ch5_m_data", {16'd0, bus6.m_data}, 64'h5A00_0000_0000);
        check("ch5_no_err", {63'd0, bus6.err}, 64'd0);
        @(negedge clk);
        bus6.s_sel = 3'd7; bus6.s_data = 8'h99;
        @(posedge clk); #1;
        check("drop_keeps_m_valid", {58'd0, bus6.m_valid}, 64'h20);
        check("drop_keeps_m_data", {16'd0, bus6.m_data}, 64'h5A00_0000_0000);
        check("err_cnt_3", {56'd0, bus6.err_cnt}, 64'd3);
        repeat (298) @(posedge clk);
        #1;
        check("err_cnt_sat", {56'd0, bus6.err_cnt}, 64'd255);
        check("err_at_sat", {63'd0, bus6.err}, 64'd1);
        @(negedge clk);
        bus6.s_valid = 1'b0;

        // Reset mid-operation with every 8-channel buffer full
        step8('{1'b0, 1'b0, 3'd0, 8'h00, 8'hFF, 1'b1, 8'h00});
        step8('{1'b1, 1'b1, 3'd0, 8'hC3, 8'h00, 1'b1, 8'hFF});
        bus8.s_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", {56'd0, bus8.m_valid}, 64'd0);
        check("mid_rst_m_data", bus8.m_data, 64'd0);
        check("mid_rst_err_cnt", {56'd0, bus6.err_cnt}, 64'd0);
        check("mid_rst_m_valid6", {58'd0, bus6.m_valid}, 64'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < NCH; i++) sbq[i].delete();
        bus8.m_ready = '1;
        @(negedge clk);
        step8('{1'b1, 1'b0, 3'd5, 8'hA5, 8'hFF, 1'b1, 8'h20});
        check("post_rst_m_data", bus8.m_data, 64'h0000_A500_0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
